clk_period_monitor: RTL and testbench

//   Receive-side checker for the divided clock produced by the clock divider:

---
 rtl/clk_period_monitor.sv | 194 +++++++++++++++++++
 tb/tb_clk_period_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: receive-side checker for the divided clock.
// Samples div_clk in the clk domain, measures every half-period in clk cycles
// and reports lock, stall and a saturating out-of-tolerance count.
// Optional glitch filter on the synchronized level: macro GLITCH_FILTER_EN.
//
// state    | meaning
// IDLE     | after reset, waiting for the first edge (its phase is unknown)
// MEASURE  | counting consecutive in-tolerance half-periods toward lock
// LOCKED   | LOCK_CNT good half-periods seen, no bad one since
// UNLOCKED | a bad half-period was seen, counting good ones again
// STALLED  | no edge for TIMEOUT cycles
module clk_period_monitor #(
   parameter int CNT_W    = 32,
   parameter int EXPECTED = 1_579_995,
   parameter int TOL      = 16,
   parameter int LOCK_CNT = 3,
   parameter int TIMEOUT  = 4_000_000,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_clk,
   input  logic             clr,
   output logic [CNT_W-1:0] half_period,
   output logic             meas_valid,
   output logic             locked,
   output logic             stalled,
   output logic [7:0]       err_cnt
);

   typedef enum logic [2:0] {IDLE, MEASURE, LOCKED, UNLOCKED, STALLED} state_t;

   localparam int               GW      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W:0]   TOL_LO  = (CNT_W+1)'(EXPECTED - TOL);
   localparam logic [CNT_W:0]   TOL_HI  = (CNT_W+1)'(EXPECTED + TOL);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   generate
      if (TOL >= EXPECTED) begin : g_bad_tol
         $error("TOL must be smaller than EXPECTED");
      end
      if (FILT_LEN < 1) begin : g_bad_filt
         $error("FILT_LEN must be at least 1");
      end
   endgenerate

   state_t           state;
   logic             s1, s2, s3;
   logic             edge_det;
   logic             tmo;
   logic             in_tol;
   logic [CNT_W-1:0] cnt;
   logic [GW-1:0]    good_cnt;

`ifdef GLITCH_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);
   logic [FW-1:0] filt_cnt;

   // s3 only follows s2 once it has disagreed for FILT_LEN consecutive samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         filt_cnt <= '0;
      end else begin
         s1 <= div_clk;
         s2 <= s1;
         if (edge_det) begin
            s3       <= s2;
            filt_cnt <= '0;
         end else if (s2 != s3) begin
            filt_cnt <= filt_cnt + 1'b1;
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign edge_det = (s2 != s3) && (filt_cnt == FW'(FILT_LEN));
`else
   // two-flop synchronizer followed by the level register used for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= div_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 ^ s3;
`endif

   // an edge in the same cycle as the timeout compare wins
   assign tmo    = (cnt == TMO) && !edge_det;
   assign in_tol = ({1'b0, half_period} >= TOL_LO) && ({1'b0, half_period} <= TOL_HI);

   // cycles since the last edge, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (edge_det) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // capture the finished half-period; cnt+1 because cnt restarts at 0 on the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_period <= '0;
         meas_valid  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (edge_det && (state == MEASURE || state == LOCKED || state == UNLOCKED)) begin
            half_period <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            meas_valid  <= 1'b1;
         end
      end
   end

   // lock / stall tracking, judged on the cycle a new measurement is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         good_cnt <= '0;
         locked   <= 1'b0;
         stalled  <= 1'b0;
      end else if (tmo) begin
         state    <= STALLED;
         good_cnt <= '0;
         locked   <= 1'b0;
         stalled  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (edge_det) state <= MEASURE;
            end
            MEASURE, UNLOCKED: begin
               if (meas_valid) begin
                  if (!in_tol) begin
                     state    <= UNLOCKED;
                     good_cnt <= '0;
                  end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                     state    <= LOCKED;
                     good_cnt <= '0;
                     locked   <= 1'b1;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (meas_valid && !in_tol) begin
                  state    <= UNLOCKED;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end
            end
            STALLED: begin
               if (edge_det) begin
                  state    <= MEASURE;
                  good_cnt <= '0;
                  stalled  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               good_cnt <= '0;
               locked   <= 1'b0;
               stalled  <= 1'b0;
            end
         endcase
      end
   end

   // saturating bad-measurement count; clr beats a simultaneous increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (clr) begin
         err_cnt <= 8'd0;
      end else if (meas_valid && !in_tol && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with EXPECTED=10 TOL=1 LOCK_CNT=3
// TIMEOUT=50 FILT_LEN=4. div_clk is driven on falling clk edges.
module tb_clk_period_monitor;

   localparam int CNT_W    = 32;
   localparam int FILT_LEN = 4;
`ifdef GLITCH_FILTER_EN
   localparam int LAT = 3 + FILT_LEN;
`else
   localparam int LAT = 3;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             div_clk;
   logic             clr;
   logic [CNT_W-1:0] half_period;
   logic             meas_valid;
   logic             locked;
   logic             stalled;
   logic [7:0]       err_cnt;

   int n_chk = 0;
   int n_bad = 0;
   int n_meas = 0;
   int st_at;
   int m0;

   clk_period_monitor #(
      .CNT_W(CNT_W), .EXPECTED(10), .TOL(1), .LOCK_CNT(3), .TIMEOUT(50), .FILT_LEN(FILT_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .clr(clr),
      .half_period(half_period), .meas_valid(meas_valid), .locked(locked),
      .stalled(stalled), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (meas_valid) n_meas++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   // toggle div_clk, hold it n cycles, check the measurement of the previous hold
   task automatic seg(input int n, input logic exp_got, input int exp_hp,
                      input logic exp_lk0, input logic exp_lk1, input string tag);
      logic        got = 1'b0;
      logic [31:0] hp = '0;
      logic        lk0 = 1'b0;
      logic        lk1 = 1'b0;
      int          at = 0;
      st_at = 0;
      div_clk = ~div_clk;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (at != 0 && i == at + 1) lk1 = locked;
         if (meas_valid && !got) begin
            got = 1'b1;
            at  = i;
            hp  = half_period;
            lk0 = locked;
         end
         if (stalled && st_at == 0) st_at = i;
      end
      chk({tag, "_got"}, 32'(got), 32'(exp_got));
      if (exp_got) begin
         chk({tag, "_hp"}, hp, exp_hp);
         chk({tag, "_lat"}, at, LAT);
         chk({tag, "_lk0"}, 32'(lk0), 32'(exp_lk0));
         chk({tag, "_lk1"}, 32'(lk1), 32'(exp_lk1));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hp0"}, half_period, 0);
      chk({tag, "_mv0"}, 32'(meas_valid), 0);
      chk({tag, "_lk0"}, 32'(locked), 0);
      chk({tag, "_st0"}, 32'(stalled), 0);
      chk({tag, "_err0"}, 32'(err_cnt), 0);
   endtask

   initial begin
      logic found;
      rst_n = 1'b0;
      div_clk = 1'b0;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      // first edge discarded, then three good halves lock
      seg(10, 1'b0, 0, 1'b0, 1'b0, "first");
      seg(10, 1'b1, 10, 1'b0, 1'b0, "g1");
      seg(10, 1'b1, 10, 1'b0, 1'b0, "g2");
      seg(13, 1'b1, 10, 1'b0, 1'b1, "g3");
      // the 13-cycle half breaks lock
      seg(10, 1'b1, 13, 1'b1, 1'b0, "bad13");
      chk("err_after13", 32'(err_cnt), 1);
      seg(10, 1'b1, 10, 1'b0, 1'b0, "r1");
      seg(10, 1'b1, 10, 1'b0, 1'b0, "r2");
      // relock, then hold 60 cycles to stall
      seg(60, 1'b1, 10, 1'b0, 1'b1, "r3");
      chk("stall_at", st_at, LAT + 51);
      chk("stall_st", 32'(stalled), 1);
      chk("stall_lk", 32'(locked), 0);
      seg(10, 1'b0, 0, 1'b0, 1'b0, "resume");
      chk("resume_st", 32'(stalled), 0);
      seg(10, 1'b1, 10, 1'b0, 1'b0, "s1");
      seg(10, 1'b1, 10, 1'b0, 1'b0, "s2");
      seg(10, 1'b1, 10, 1'b0, 1'b1, "s3");
      seg(10, 1'b1, 10, 1'b1, 1'b1, "s4");
      chk("err_after_stall", 32'(err_cnt), 1);

      // 2-cycle glitch on a steady level
      m0 = n_meas;
      div_clk = ~div_clk;
      repeat (2) @(negedge clk);
      div_clk = ~div_clk;
      repeat (20) @(negedge clk);
`ifdef GLITCH_FILTER_EN
      chk("gl_nmeas", n_meas - m0, 0);
      chk("gl_err", 32'(err_cnt), 1);
      chk("gl_lk", 32'(locked), 1);
      chk("gl_hp", half_period, 10);
`else
      chk("gl_nmeas", n_meas - m0, 2);
      chk("gl_err", 32'(err_cnt), 2);
      chk("gl_lk", 32'(locked), 0);
      chk("gl_hp", half_period, 2);
`endif

      // 300 bad halves saturate the error count
      for (int i = 0; i < 300; i++) begin
         div_clk = ~div_clk;
         repeat (5) @(negedge clk);
      end
      chk("err_sat", 32'(err_cnt), 255);
      chk("sat_hp", half_period, 5);

      // clr coinciding with a bad measurement
      found = 1'b0;
      div_clk = ~div_clk;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (meas_valid) found = 1'b1;
      end
      chk("clr_meas_seen", 32'(found), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_err", 32'(err_cnt), 0);
      div_clk = ~div_clk;
      repeat (12) @(negedge clk);
      chk("post_clr_err", 32'(err_cnt), 1);

      // asynchronous reset in mid-run
      #3;
      rst_n = 1'b0;
      div_clk = 1'b0;
      #1;
      chk_zero("mid_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seg(10, 1'b0, 0, 1'b0, 1'b0, "mr_first");
      seg(10, 1'b1, 10, 1'b0, 1'b0, "mr_g1");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
